t9990_vram_arbiter_n: RTL and testbench

- Parametrised VRAM arbiter for the tiny9990 core: NUM_CLIENTS requesters (display fetchers, sprite, blitter, CPU port) share one external RAM port.
- Generalises the fixed client set into two groups. Real-time clients (indices 0..NUM_RT-1) use fixed priority. Best-effort clients (NUM_RT..NUM_CLIENTS-1) use round-robin.
- Adds a self-timed refresh scheduler with a backlog counter.
- Sits between the per-module memory interfaces and the RAM pins (RAM_OE_n/RAM_WE_n/RAM_RFSH_n/RAM_ACK_n).

---
 rtl/t9990_vram_arbiter_n.sv | 246 ++++++++++++++++++++++++
 tb/tb_t9990_vram_arbiter_n.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/t9990_vram_arbiter_n.sv
// VRAM arbiter for tiny9990: fixed-priority real-time clients, round-robin best-effort clients, self-timed refresh.
// Optional starvation promotion for best-effort clients when T9990_ARB_STARVE_EN is defined.
module t9990_vram_arbiter_n #(
  parameter int NUM_CLIENTS      = 6,
  parameter int NUM_RT           = 4,
  parameter int ADDR_W           = 19,
  parameter int DATA_W           = 32,
  parameter int RFSH_INTERVAL    = 64,
  parameter int RFSH_MAX_BACKLOG = 2
) (
  input  logic                          CLK,
  input  logic                          RESET_n,
  input  logic                          SLOT_EN,
  input  logic [NUM_CLIENTS-1:0]        REQ,
  input  logic [NUM_CLIENTS-1:0]        WE,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] ADDR,
  input  logic [NUM_CLIENTS*DATA_W-1:0] DIN,
  input  logic [NUM_CLIENTS*2-1:0]      SIZE,
  output logic [NUM_CLIENTS-1:0]        GNT,
  output logic [NUM_CLIENTS-1:0]        VALID,
  output logic [DATA_W-1:0]             DOUT,
  output logic                          RAM_OE_n,
  output logic                          RAM_WE_n,
  output logic                          RAM_RFSH_n,
  output logic [ADDR_W-1:0]             RAM_ADDR,
  output logic [DATA_W-1:0]             RAM_DIN,
  output logic [1:0]                    RAM_DIN_SIZE,
  input  logic [DATA_W-1:0]             RAM_DOUT,
  input  logic                          RAM_ACK_n,
  output logic                          BUSY
);

  localparam int unsigned NC    = NUM_CLIENTS;
  localparam int unsigned NRT   = NUM_RT;
  localparam int unsigned NBE   = NUM_CLIENTS - NUM_RT;
  localparam int unsigned IDX_W = $clog2(NUM_CLIENTS);
  localparam int unsigned CNT_W = (RFSH_INTERVAL > 1) ? $clog2(RFSH_INTERVAL) : 1;
  localparam int unsigned BL_W  = $clog2(RFSH_MAX_BACKLOG + 2);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RFSH} state_t;

  state_t state, state_next;

  logic [IDX_W-1:0]  rr_ptr;
  logic [CNT_W-1:0]  slot_cnt;
  logic [BL_W-1:0]   backlog;
  logic [IDX_W-1:0]  cur_idx;
  logic              cur_we;

  logic [ADDR_W-1:0] addr_arr [NC];
  logic [DATA_W-1:0] din_arr  [NC];
  logic [1:0]        size_arr [NC];

  logic              rt_found;
  logic [IDX_W-1:0]  rt_idx;
  logic              be_found;
  logic [IDX_W-1:0]  be_idx;
  logic [IDX_W:0]    cand;
  logic              starve_found;
  logic [IDX_W-1:0]  starve_idx;

  logic              dec_rfsh;
  logic              dec_client;
  logic              dec_rr_upd;
  logic [IDX_W-1:0]  dec_idx;
  logic [IDX_W-1:0]  rr_next;
  logic              slot_fire;
  logic [NC-1:0]     gnt_int;
  logic              tick_wrap;
  logic              rfsh_done;

  always_comb begin
    for (int unsigned i = 0; i < NC; i++) begin
      addr_arr[i] = ADDR[i*ADDR_W +: ADDR_W];
      din_arr[i]  = DIN[i*DATA_W +: DATA_W];
      size_arr[i] = SIZE[i*2 +: 2];
    end
  end

  always_comb begin
    rt_found = 1'b0;
    rt_idx   = '0;
    for (int unsigned i = 0; i < NRT; i++) begin
      if (!rt_found && REQ[i]) begin
        rt_found = 1'b1;
        rt_idx   = IDX_W'(i);
      end
    end
  end

  // Scan best-effort clients starting at rr_ptr, folding indices past the top back to NUM_RT.
  always_comb begin
    be_found = 1'b0;
    be_idx   = '0;
    cand     = '0;
    for (int unsigned k = 0; k < NBE; k++) begin
      cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NC)) cand = cand - (IDX_W+1)'(NBE);
      if (!be_found && REQ[cand[IDX_W-1:0]]) begin
        be_found = 1'b1;
        be_idx   = cand[IDX_W-1:0];
      end
    end
  end

`ifdef T9990_ARB_STARVE_EN
  logic [5:0] wait_cnt [NBE];

  always_comb begin
    starve_found = 1'b0;
    starve_idx   = '0;
    for (int unsigned i = 0; i < NBE; i++) begin
      if (!starve_found && REQ[NRT+i] && wait_cnt[i] == 6'd63) begin
        starve_found = 1'b1;
        starve_idx   = IDX_W'(NRT + i);
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      for (int unsigned i = 0; i < NBE; i++) wait_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NBE; i++) begin
        if (!REQ[NRT+i] || gnt_int[NRT+i]) wait_cnt[i] <= '0;
        else if (SLOT_EN && wait_cnt[i] != 6'd63) wait_cnt[i] <= wait_cnt[i] + 6'd1;
      end
    end
  end
`else
  always_comb begin
    starve_found = 1'b0;
    starve_idx   = '0;
  end
`endif

  always_comb begin
    dec_rfsh   = 1'b0;
    dec_client = 1'b0;
    dec_rr_upd = 1'b0;
    dec_idx    = '0;
    if (backlog >= BL_W'(RFSH_MAX_BACKLOG)) begin
      dec_rfsh = 1'b1;
    end else if (starve_found) begin
      dec_client = 1'b1;
      dec_idx    = starve_idx;
    end else if (rt_found) begin
      dec_client = 1'b1;
      dec_idx    = rt_idx;
    end else if (backlog != '0) begin
      dec_rfsh = 1'b1;
    end else if (be_found) begin
      dec_client = 1'b1;
      dec_rr_upd = 1'b1;
      dec_idx    = be_idx;
    end
  end

  assign rr_next   = (dec_idx == IDX_W'(NC - 1)) ? IDX_W'(NRT) : dec_idx + IDX_W'(1);
  assign slot_fire = (state == S_IDLE) && SLOT_EN;
  assign gnt_int   = (slot_fire && dec_client) ? (NC'(1) << dec_idx) : '0;
  assign GNT       = RESET_n ? gnt_int : '0;
  assign BUSY      = (state != S_IDLE);
  assign tick_wrap = SLOT_EN && (slot_cnt == CNT_W'(RFSH_INTERVAL - 1));
  assign rfsh_done = (state == S_RFSH) && !RAM_ACK_n;

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (slot_fire && dec_rfsh)        state_next = S_RFSH;
        else if (slot_fire && dec_client) state_next = S_ACCESS;
      end
      S_ACCESS: if (!RAM_ACK_n) state_next = S_IDLE;
      S_RFSH:   if (!RAM_ACK_n) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) state <= S_IDLE;
    else          state <= state_next;
  end

  // Coincident interval wrap and refresh completion cancel out.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      slot_cnt <= '0;
      backlog  <= '0;
    end else begin
      if (SLOT_EN) slot_cnt <= tick_wrap ? '0 : slot_cnt + CNT_W'(1);
      if (tick_wrap && !rfsh_done) begin
        if (backlog != BL_W'(RFSH_MAX_BACKLOG + 1)) backlog <= backlog + BL_W'(1);
      end else if (rfsh_done && !tick_wrap) begin
        backlog <= backlog - BL_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      rr_ptr       <= IDX_W'(NRT);
      cur_idx      <= '0;
      cur_we       <= 1'b0;
      VALID        <= '0;
      DOUT         <= '0;
      RAM_OE_n     <= 1'b1;
      RAM_WE_n     <= 1'b1;
      RAM_RFSH_n   <= 1'b1;
      RAM_ADDR     <= '0;
      RAM_DIN      <= '0;
      RAM_DIN_SIZE <= '0;
    end else begin
      VALID <= '0;
      case (state)
        S_IDLE: begin
          if (slot_fire && dec_rfsh) begin
            RAM_RFSH_n <= 1'b0;
          end else if (slot_fire && dec_client) begin
            cur_idx      <= dec_idx;
            cur_we       <= WE[dec_idx];
            RAM_OE_n     <= WE[dec_idx];
            RAM_WE_n     <= !WE[dec_idx];
            RAM_ADDR     <= addr_arr[dec_idx];
            RAM_DIN      <= din_arr[dec_idx];
            RAM_DIN_SIZE <= size_arr[dec_idx];
            if (dec_rr_upd) rr_ptr <= rr_next;
          end
        end
        S_ACCESS: begin
          if (!RAM_ACK_n) begin
            if (!cur_we) DOUT <= RAM_DOUT;
            VALID    <= NC'(1) << cur_idx;
            RAM_OE_n <= 1'b1;
            RAM_WE_n <= 1'b1;
          end
        end
        S_RFSH: begin
          if (!RAM_ACK_n) RAM_RFSH_n <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_t9990_vram_arbiter_n.sv
// Self-checking bench for t9990_vram_arbiter_n: directed scenarios plus randomized slots against a transaction-level model.
module tb_t9990_vram_arbiter_n;

  localparam int NC  = 6;
  localparam int NR  = 4;
  localparam int NBE = NC - NR;
  localparam int AW  = 19;
  localparam int DW  = 32;
  localparam int RFI = 16;
  localparam int MAX = 2;

  logic              CLK = 1'b0;
  logic              RESET_n;
  logic              SLOT_EN;
  logic [NC-1:0]     REQ, WE;
  logic [NC*AW-1:0]  ADDR;
  logic [NC*DW-1:0]  DIN;
  logic [NC*2-1:0]   SIZE;
  logic [NC-1:0]     GNT, VALID;
  logic [DW-1:0]     DOUT;
  logic              RAM_OE_n, RAM_WE_n, RAM_RFSH_n;
  logic [AW-1:0]     RAM_ADDR;
  logic [DW-1:0]     RAM_DIN;
  logic [1:0]        RAM_DIN_SIZE;
  logic [DW-1:0]     RAM_DOUT;
  logic              RAM_ACK_n;
  logic              BUSY;

  t9990_vram_arbiter_n #(
    .NUM_CLIENTS(NC), .NUM_RT(NR), .ADDR_W(AW), .DATA_W(DW),
    .RFSH_INTERVAL(RFI), .RFSH_MAX_BACKLOG(MAX)
  ) dut (
    .CLK(CLK), .RESET_n(RESET_n), .SLOT_EN(SLOT_EN), .REQ(REQ), .WE(WE),
    .ADDR(ADDR), .DIN(DIN), .SIZE(SIZE), .GNT(GNT), .VALID(VALID), .DOUT(DOUT),
    .RAM_OE_n(RAM_OE_n), .RAM_WE_n(RAM_WE_n), .RAM_RFSH_n(RAM_RFSH_n),
    .RAM_ADDR(RAM_ADDR), .RAM_DIN(RAM_DIN), .RAM_DIN_SIZE(RAM_DIN_SIZE),
    .RAM_DOUT(RAM_DOUT), .RAM_ACK_n(RAM_ACK_n), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int n_assert = 0;
  int n_fail   = 0;
  int gnt4_cnt = 0;

  // Reference model: refresh debt, round-robin pointer, per-client wait counts, last read data.
  int          m_backlog;
  int          m_slots;
  int          m_rr;
  int          m_wait [NC];
  logic [DW-1:0] m_dout;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic m_reset();
    m_backlog = 0;
    m_slots   = 0;
    m_rr      = NR;
    m_dout    = '0;
    for (int i = 0; i < NC; i++) m_wait[i] = 0;
  endtask

  task automatic m_event(input bit slot, input bit rf_done);
    bit inc;
    inc = 1'b0;
    if (slot) begin
      m_slots++;
      inc = (m_slots % RFI) == 0;
    end
    if (inc && !rf_done) begin
      if (m_backlog < MAX + 1) m_backlog++;
    end else if (rf_done && !inc) begin
      m_backlog--;
    end
  endtask

  task automatic m_wait_slot(input int granted);
    for (int i = NR; i < NC; i++) begin
      if (REQ[i] && i != granted) m_wait[i] = (m_wait[i] < 63) ? m_wait[i] + 1 : 63;
      else m_wait[i] = 0;
    end
  endtask

  // w: client index, -2 refresh, -1 nothing; rr flags a round-robin win
  task automatic m_pick(output int w, output bit rr);
    w  = -1;
    rr = 1'b0;
    if (m_backlog >= MAX) begin w = -2; return; end
`ifdef T9990_ARB_STARVE_EN
    for (int i = NR; i < NC; i++)
      if (REQ[i] && m_wait[i] >= 63) begin w = i; return; end
`endif
    for (int i = 0; i < NR; i++)
      if (REQ[i]) begin w = i; return; end
    if (m_backlog > 0) begin w = -2; return; end
    for (int k = 0; k < NBE; k++) begin
      int i;
      i = NR + ((m_rr - NR + k) % NBE);
      if (REQ[i]) begin w = i; rr = 1'b1; return; end
    end
  endtask

  task automatic set_req(input logic [NC-1:0] v);
    REQ = v;
    for (int i = 0; i < NC; i++) if (!v[i]) m_wait[i] = 0;
  endtask

  task automatic rand_payload();
    for (int i = 0; i < NC; i++) begin
      ADDR[i*AW +: AW] = AW'($urandom);
      DIN[i*DW +: DW]  = $urandom;
      SIZE[i*2 +: 2]   = ($urandom_range(0, 1) == 1) ? 2'd2 : 2'd0;
      WE[i]            = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic do_slot(input int ack_delay, input bit busy_slots, output int w);
    bit            rr, sl;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din, rd;
    logic [1:0]    e_size;
    logic [NC-1:0] e_gnt;
    rand_payload();
    m_pick(w, rr);
    e_gnt = (w >= 0) ? (NC'(1) << w) : '0;
    e_we = 1'b0; e_addr = '0; e_din = '0; e_size = '0;
    if (w >= 0) begin
      e_we = WE[w]; e_addr = ADDR[w*AW +: AW]; e_din = DIN[w*DW +: DW]; e_size = SIZE[w*2 +: 2];
    end
    SLOT_EN = 1'b1;
    #3;
    check("gnt_slot", GNT, e_gnt);
    if (GNT[4]) gnt4_cnt++;
    tick();
    SLOT_EN = 1'b0;
    m_event(1'b1, 1'b0);
    m_wait_slot(w);
    if (rr) m_rr = (w == NC - 1) ? NR : w + 1;
    rand_payload();
    if (w == -1) begin
      check("idle_busy", BUSY, 1'b0);
      check("idle_strobes", {RAM_OE_n, RAM_WE_n, RAM_RFSH_n}, 3'b111);
      return;
    end
    if (w >= 0) begin
      check("acc_strobes", {RAM_OE_n, RAM_WE_n, RAM_RFSH_n}, {e_we, !e_we, 1'b1});
      check("acc_addr", RAM_ADDR, e_addr);
      check("acc_din", RAM_DIN, e_din);
      check("acc_size", RAM_DIN_SIZE, e_size);
    end else begin
      check("rfsh_strobes", {RAM_OE_n, RAM_WE_n, RAM_RFSH_n}, 3'b110);
    end
    check("busy_on", BUSY, 1'b1);
    for (int d = 0; d < ack_delay; d++) begin
      sl = busy_slots && ($urandom_range(0, 2) == 0);
      SLOT_EN = sl;
      #3;
      if (sl) check("gnt_lost_slot", GNT, '0);
      tick();
      SLOT_EN = 1'b0;
      m_event(sl, 1'b0);
      if (sl) m_wait_slot(-1);
    end
    sl = busy_slots && ($urandom_range(0, 1) == 0);
    rd = $urandom;
    RAM_DOUT  = rd;
    RAM_ACK_n = 1'b0;
    SLOT_EN   = sl;
    #3;
    if (w >= 0) check("strobe_hold", RAM_OE_n & RAM_WE_n, 1'b0);
    else        check("rfsh_hold", RAM_RFSH_n, 1'b0);
    tick();
    RAM_ACK_n = 1'b1;
    SLOT_EN   = 1'b0;
    m_event(sl, w == -2);
    if (sl) m_wait_slot(-1);
    if (w >= 0) begin
      if (!e_we) m_dout = rd;
      check("valid", VALID, NC'(1) << w);
    end else begin
      check("rfsh_novalid", VALID, '0);
    end
    check("dout", DOUT, m_dout);
    check("release", {RAM_OE_n, RAM_WE_n, RAM_RFSH_n, BUSY}, 4'b1110);
    tick();
    check("valid_pulse", VALID, '0);
  endtask

  task automatic apply_reset();
    RESET_n = 1'b0;
    SLOT_EN = 1'b0;
    RAM_ACK_n = 1'b1;
    tick();
    tick();
    RESET_n = 1'b1;
    m_reset();
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    RESET_n = 1'b0; SLOT_EN = 1'b0; REQ = '0; WE = '0; ADDR = '0; DIN = '0; SIZE = '0;
    RAM_DOUT = '0; RAM_ACK_n = 1'b1;
    m_reset();
    tick();
    tick();
    check("rst_gnt", GNT, '0);
    check("rst_valid", VALID, '0);
    check("rst_dout", DOUT, '0);
    check("rst_strobes", {RAM_OE_n, RAM_WE_n, RAM_RFSH_n}, 3'b111);
    check("rst_addr", RAM_ADDR, '0);
    check("rst_din", {RAM_DIN, RAM_DIN_SIZE}, '0);
    check("rst_busy", BUSY, 1'b0);
    RESET_n = 1'b1;
    tick();

    // Two real-time clients: lowest index first, then the other once client 0 drops.
    set_req(6'b000011);
    do_slot(3, 1'b0, w);
    set_req(6'b000010);
    do_slot(0, 1'b0, w);

    // Best-effort round robin between clients 4 and 5.
    set_req(6'b110000);
    repeat (4) do_slot(0, 1'b0, w);

    // Idle refresh drain, then forced refresh against a held real-time request.
    set_req('0);
    repeat (40) do_slot($urandom_range(0, 2), 1'b0, w);
    set_req(6'b000001);
    repeat (40) do_slot($urandom_range(0, 2), 1'b1, w);

    // Long access with slots arriving while busy.
    set_req(6'b000100);
    do_slot(20, 1'b1, w);

    repeat (250) begin
      set_req(NC'($urandom));
      do_slot($urandom_range(0, 4), 1'b1, w);
      repeat ($urandom_range(0, 2)) tick();
    end

    // Best-effort client 4 competing with an always-requesting real-time client.
    apply_reset();
    gnt4_cnt = 0;
    set_req(6'b010001);
    repeat (80) do_slot(0, 1'b0, w);
`ifdef T9990_ARB_STARVE_EN
    check("starve_gnt4", gnt4_cnt > 0, 1'b1);
`else
    check("no_starve_gnt4", gnt4_cnt, 0);
`endif

    // Reset in the middle of an access.
    apply_reset();
    set_req(6'b000001);
    WE = '0;
    SLOT_EN = 1'b1;
    #3;
    check("pre_rst_gnt", GNT, 6'b000001);
    tick();
    SLOT_EN = 1'b0;
    check("pre_rst_oe", RAM_OE_n, 1'b0);
    tick();
    SLOT_EN = 1'b1;
    RESET_n = 1'b0;
    #1;
    check("midrst_strobes", {RAM_OE_n, RAM_WE_n, RAM_RFSH_n}, 3'b111);
    check("midrst_gnt_valid", {GNT, VALID}, '0);
    check("midrst_busy", BUSY, 1'b0);
    SLOT_EN = 1'b0;
    tick();
    RESET_n = 1'b1;
    m_reset();
    tick();
    set_req(6'b000100);
    do_slot(1, 1'b0, w);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
